// File: rtl/gpu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// gpu_cmd_issuer
//
// CPU-side initiator of the graphics command handshake. Each `issue` pulse from
// the ISDU captures {IR[11:9], IR[7:0], R0, R1, R2} into a small FIFO. Entries
// are presented to the graphics unit in order. A 2-bit sequence number
// (command_ready) advances once per presented command. The receiver
// acknowledges by echoing that number on command_received. At most one command
// is outstanding at a time.
//
// Parameters:
//   DEPTH   - FIFO entries; a power of two in 2..16.
//   TIMEOUT - acknowledge timeout in WAIT cycles (GPU_TIMEOUT_EN builds only).
//
// Ports:
//   Clk, Reset_ah          - clock; asynchronous active-high reset
//   issue, IR, R0..R2      - push request and the fields it captures
//   command, command_data  - command code and data for the current command
//   op0, op1, op2          - operands for the current command
//   command_ready          - transmit sequence number
//   command_received       - receiver's last consumed sequence number
//   stall                  - FIFO full (or ERROR); the ISDU must hold off issue
//   empty                  - nothing queued and nothing outstanding
//   count                  - FIFO occupancy, excluding the in-flight command
//   overflow               - sticky: an issue was dropped
//   timeout                - sticky: acknowledge timed out
//
// Build option: define GPU_TIMEOUT_EN to add the acknowledge timeout counter
// and the terminal ERROR state. Without it, timeout is tied to 0 and WAIT
// holds indefinitely.
// -----------------------------------------------------------------------------
module gpu_cmd_issuer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                    Clk,
    input  logic                    Reset_ah,
    input  logic                    issue,
    input  logic [15:0]             IR,
    input  logic [15:0]             R0,
    input  logic [15:0]             R1,
    input  logic [15:0]             R2,
    output logic [2:0]              command,
    output logic [7:0]              command_data,
    output logic [15:0]             op0,
    output logic [15:0]             op1,
    output logic [15:0]             op2,
    output logic [1:0]              command_ready,
    input  logic [1:0]              command_received,
    output logic                    stall,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("gpu_cmd_issuer: DEPTH must be a power of two in 2..16, TIMEOUT >= 1");
    end

    typedef struct packed {
        logic [2:0]  cmd;
        logic [7:0]  data;
        logic [15:0] op0;
        logic [15:0] op1;
        logic [15:0] op2;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1
`ifdef GPU_TIMEOUT_EN
        ,
        ST_ERROR = 2'd2
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2:0]      command_q, command_d;
    logic [7:0]      command_data_q, command_data_d;
    logic [15:0]     op0_q, op0_d;
    logic [15:0]     op1_q, op1_d;
    logic [15:0]     op2_q, op2_d;
    logic [1:0]      command_ready_q, command_ready_d;
    logic            overflow_q, overflow_d;

`ifdef GPU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            timeout_q, timeout_d;
`endif

    entry_t          fifo_mem [DEPTH];
    entry_t          wr_entry;
    entry_t          head_entry;
    logic            ack;
    logic            pop;
    logic            push;
    logic            accepting;
    logic            full;

    // IR[15:12] and IR[8] carry no command information.
    logic            unused_ir_bits;
    assign unused_ir_bits = ^{IR[15:12], IR[8]};

    assign wr_entry   = {IR[11:9], IR[7:0], R0, R1, R2};
    assign head_entry = fifo_mem[head_q];
    assign ack        = (command_received == command_ready_q);
    assign full       = (count_q == FULL_COUNT);

    // NOTE: every variable gets a hold/default value before the case so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d         = state_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        command_d       = command_q;
        command_data_d  = command_data_q;
        op0_d           = op0_q;
        op1_d           = op1_q;
        op2_d           = op2_q;
        command_ready_d = command_ready_q;
        overflow_d      = overflow_q;
        pop             = 1'b0;
        push            = 1'b0;
        accepting       = 1'b1;
`ifdef GPU_TIMEOUT_EN
        tmo_cnt_d       = tmo_cnt_q;
        timeout_d       = timeout_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = ST_WAIT;
`ifdef GPU_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (ack) begin
                    // Back-to-back: the next head goes out on the ack edge.
                    if (count_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
`ifdef GPU_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
`ifdef GPU_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = ST_ERROR;
                    timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
`endif
            end
`ifdef GPU_TIMEOUT_EN
            ST_ERROR: begin
                // Terminal until reset: outputs frozen, issue ignored silently.
                accepting = 1'b0;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            command_d       = head_entry.cmd;
            command_data_d  = head_entry.data;
            op0_d           = head_entry.op0;
            op1_d           = head_entry.op1;
            op2_d           = head_entry.op2;
            command_ready_d = command_ready_q + 2'd1;
            head_d          = head_q + AW'(1);
        end

        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        push = issue && accepting && (!full || pop);
        if (issue && accepting && full && !pop) begin
            overflow_d = 1'b1;
        end
        if (push) begin
            tail_d = tail_q + AW'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            state_q         <= ST_IDLE;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            command_q       <= '0;
            command_data_q  <= '0;
            op0_q           <= '0;
            op1_q           <= '0;
            op2_q           <= '0;
            command_ready_q <= '0;
            overflow_q      <= 1'b0;
`ifdef GPU_TIMEOUT_EN
            tmo_cnt_q       <= '0;
            timeout_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            command_q       <= command_d;
            command_data_q  <= command_data_d;
            op0_q           <= op0_d;
            op1_q           <= op1_d;
            op2_q           <= op2_d;
            command_ready_q <= command_ready_d;
            overflow_q      <= overflow_d;
`ifdef GPU_TIMEOUT_EN
            tmo_cnt_q       <= tmo_cnt_d;
            timeout_q       <= timeout_d;
`endif
        end
    end

    // NOTE: FIFO storage is deliberately not reset; count/pointers guarantee no
    // stale entry is ever read, and leaving it reset-free lets it map to RAM.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_mem[tail_q] <= wr_entry;
        end
    end

    assign command       = command_q;
    assign command_data  = command_data_q;
    assign op0           = op0_q;
    assign op1           = op1_q;
    assign op2           = op2_q;
    assign command_ready = command_ready_q;
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign empty         = (count_q == '0) && (state_q == ST_IDLE);

`ifdef GPU_TIMEOUT_EN
    assign stall   = full || (state_q == ST_ERROR);
    assign timeout = timeout_q;
`else
    assign stall   = full;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gpu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// tb_gpu_cmd_issuer
//
// Directed bench for gpu_cmd_issuer (DEPTH=4, TIMEOUT=8). The bench plays both
// the ISDU (issue/IR/R0..R2) and the graphics unit (command_received).
// Expected values are hand-derived constants from the entry tables below.
// -----------------------------------------------------------------------------
module tb_gpu_cmd_issuer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic        Clk = 1'b0;
    logic        Reset_ah;
    logic        issue;
    logic [15:0] IR, R0, R1, R2;
    logic [2:0]  command;
    logic [7:0]  command_data;
    logic [15:0] op0, op1, op2;
    logic [1:0]  command_ready;
    logic [1:0]  command_received;
    logic        stall, empty, overflow, timeout;
    logic [$clog2(DEPTH):0] count;

    int n_vec = 0;
    int n_err = 0;

    // Entry i: cmd = i+1, data = 8'hA0+i; IR has junk in [15:12] and [8].
    logic [15:0] ir_tab   [7] = '{16'hF3A0, 16'hF5A1, 16'hF7A2, 16'hF9A3,
                                  16'hFBA4, 16'hFDA5, 16'hFFA6};
    logic [2:0]  cmd_tab  [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [7:0]  data_tab [7] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};

    gpu_cmd_issuer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clk              (Clk),
        .Reset_ah         (Reset_ah),
        .issue            (issue),
        .IR               (IR),
        .R0               (R0),
        .R1               (R1),
        .R2               (R2),
        .command          (command),
        .command_data     (command_data),
        .op0              (op0),
        .op1              (op1),
        .op2              (op2),
        .command_ready    (command_ready),
        .command_received (command_received),
        .stall            (stall),
        .empty            (empty),
        .count            (count),
        .overflow         (overflow),
        .timeout          (timeout)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_entry(input int i);
        issue = 1'b1;
        IR    = ir_tab[i];
        R0    = 16'h1000 + 16'(i);
        R1    = 16'h2000 + 16'(i);
        R2    = 16'h3000 + 16'(i);
    endtask

    task automatic check_entry(input string tag, input int i);
        check({tag, ".cmd"},  64'(command),      64'(cmd_tab[i]));
        check({tag, ".data"}, 64'(command_data), 64'(data_tab[i]));
        check({tag, ".op0"},  64'(op0),          64'(16'h1000 + 16'(i)));
        check({tag, ".op1"},  64'(op1),          64'(16'h2000 + 16'(i)));
        check({tag, ".op2"},  64'(op2),          64'(16'h3000 + 16'(i)));
    endtask

    task automatic do_reset();
        Reset_ah         = 1'b1;
        issue            = 1'b0;
        command_received = 2'd0;
        tick();
        tick();
        Reset_ah = 1'b0;
    endtask

    initial begin
        Reset_ah         = 1'b1;
        issue            = 1'b0;
        IR               = '0;
        R0               = '0;
        R1               = '0;
        R2               = '0;
        command_received = 2'd0;
        tick();
        tick();

        // ---- reset state ----
        check("rst.command",  64'(command),       64'd0);
        check("rst.data",     64'(command_data),  64'd0);
        check("rst.op0",      64'(op0),           64'd0);
        check("rst.ready",    64'(command_ready), 64'd0);
        check("rst.stall",    64'(stall),         64'd0);
        check("rst.empty",    64'(empty),         64'd1);
        check("rst.count",    64'(count),         64'd0);
        check("rst.overflow", 64'(overflow),      64'd0);
        check("rst.timeout",  64'(timeout),       64'd0);
        Reset_ah = 1'b0;
        tick();

        // ---- single command, hold, ack ----
        issue = 1'b1; IR = 16'h0A55; R0 = 16'd10; R1 = 16'd20; R2 = 16'h00FF;
        tick();
        issue = 1'b0;
        check("t1.count_push", 64'(count), 64'd1);
        check("t1.empty_push", 64'(empty), 64'd0);
        IR = 16'h0000; R0 = 16'hDEAD; R1 = 16'hBEEF; R2 = 16'h1234;
        tick();
        check("t1.cmd",   64'(command),       64'd5);
        check("t1.data",  64'(command_data),  64'h55);
        check("t1.op0",   64'(op0),           64'd10);
        check("t1.op1",   64'(op1),           64'd20);
        check("t1.op2",   64'(op2),           64'h00FF);
        check("t1.ready", 64'(command_ready), 64'd1);
        check("t1.count", 64'(count),         64'd0);
        check("t1.empty", 64'(empty),         64'd0);
        repeat (5) tick();
        check("t1.hold_cmd",   64'(command),       64'd5);
        check("t1.hold_op0",   64'(op0),           64'd10);
        check("t1.hold_op2",   64'(op2),           64'h00FF);
        check("t1.hold_ready", 64'(command_ready), 64'd1);
        command_received = 2'd1;
        tick();
        check("t1.ack_empty", 64'(empty),         64'd1);
        check("t1.ack_cmd",   64'(command),       64'd5);
        check("t1.ack_ready", 64'(command_ready), 64'd1);

        // ---- fill with no ack: 1 in flight + 4 queued ----
        for (int i = 0; i < 5; i++) begin
            drive_entry(i);
            tick();
        end
        issue = 1'b0;
        check("t2.count", 64'(count),         64'd4);
        check("t2.stall", 64'(stall),         64'd1);
        check("t2.ovf",   64'(overflow),      64'd0);
        check("t2.ready", 64'(command_ready), 64'd2);
        check_entry("t2.inflight", 0);

        // ---- full: ack and issue on the same edge ----
        command_received = 2'd2;
        drive_entry(5);
        tick();
        issue = 1'b0;
        check("t2.same_count", 64'(count),         64'd4);
        check("t2.same_ovf",   64'(overflow),      64'd0);
        check("t2.same_stall", 64'(stall),         64'd1);
        check("t2.same_ready", 64'(command_ready), 64'd3);
        check_entry("t2.same", 1);

        // ---- full, no pop: dropped ----
        drive_entry(6);
        tick();
        issue = 1'b0;
        check("t2.drop_ovf",   64'(overflow), 64'd1);
        check("t2.drop_count", 64'(count),    64'd4);
        check_entry("t2.drop", 1);

        // ---- drain in order: entries 2,3,4,5 (entry 6 was dropped) ----
        for (int j = 0; j < 4; j++) begin
            command_received = 2'((3 + j) % 4);
            tick();
            check_entry("t2.drain", j + 2);
            check("t2.drain_ready", 64'(command_ready), 64'(j));
            check("t2.drain_count", 64'(count),         64'(3 - j));
        end
        command_received = 2'd3;
        tick();
        check("t2.idle_empty", 64'(empty),    64'd1);
        check("t2.ovf_sticky", 64'(overflow), 64'd1);
        check_entry("t2.idle", 5);

        // ---- async reset mid-WAIT with count=2 ----
        drive_entry(0); tick();
        drive_entry(1); tick();
        drive_entry(2); tick();
        issue = 1'b0;
        check("t3.pre_count", 64'(count), 64'd2);
        check_entry("t3.pre", 0);
        #2;
        Reset_ah         = 1'b1;
        command_received = 2'd0;
        #1;
        check("t3.rst_ready", 64'(command_ready), 64'd0);
        check("t3.rst_count", 64'(count),         64'd0);
        check("t3.rst_op0",   64'(op0),           64'd0);
        check("t3.rst_cmd",   64'(command),       64'd0);
        check("t3.rst_stall", 64'(stall),         64'd0);
        check("t3.rst_empty", 64'(empty),         64'd1);
        check("t3.rst_ovf",   64'(overflow),      64'd0);
        tick();
        Reset_ah = 1'b0;
        drive_entry(3);
        tick();
        issue = 1'b0;
        tick();
        check_entry("t3.fresh", 3);
        check("t3.fresh_ready", 64'(command_ready), 64'd1);

        // ---- immediate ack every cycle across 6 commands ----
        do_reset();
        for (int k = 0; k <= 6; k++) begin
            if (k < 6) begin
                drive_entry(k);
            end else begin
                issue = 1'b0;
            end
            tick();
            if (k >= 1) begin
                check_entry("t5.seq", k - 1);
                check("t5.ready", 64'(command_ready), 64'(k % 4));
                check("t5.count", 64'(count),         64'((k < 6) ? 1 : 0));
                command_received = 2'(k % 4);
            end
        end
        issue = 1'b0;
        tick();
        check("t5.empty", 64'(empty), 64'd1);
        check("t5.ovf",   64'(overflow), 64'd0);

`ifdef GPU_TIMEOUT_EN
        // ---- acknowledge timeout ----
        do_reset();
        drive_entry(4);
        tick();
        issue = 1'b0;
        tick();
        repeat (7) tick();
        check("t6.tmo_early",   64'(timeout), 64'd0);
        check("t6.stall_early", 64'(stall),   64'd0);
        tick();
        check("t6.tmo",   64'(timeout), 64'd1);
        check("t6.stall", 64'(stall),   64'd1);
        drive_entry(5);
        tick();
        tick();
        issue = 1'b0;
        check("t6.ign_ovf",   64'(overflow),      64'd0);
        check("t6.ign_count", 64'(count),         64'd0);
        check("t6.ign_ready", 64'(command_ready), 64'd1);
        check("t6.ign_stall", 64'(stall),         64'd1);
        check_entry("t6.ign", 4);
`else
        // ---- without the timeout build WAIT holds indefinitely ----
        do_reset();
        drive_entry(4);
        tick();
        issue = 1'b0;
        tick();
        repeat (20) tick();
        check("t6.no_tmo",   64'(timeout),       64'd0);
        check("t6.no_stall", 64'(stall),         64'd0);
        check("t6.ready",    64'(command_ready), 64'd1);
        check("t6.empty",    64'(empty),         64'd0);
        check_entry("t6.hold", 4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpu_cmd_issuer.md
Name: gpu_cmd_issuer

Overview:
- CPU-side transmitter for the graphics command interface: the initiator end of the command / command_ready / command_received handshake that graphics_unit responds to.
- When the ISDU executes a graphics instruction, it pulses issue. The block captures the command fields from IR and the operands R0–R2 into a small FIFO, then presents each entry to the graphics unit in order.
- It uses a 2-bit sequence-number handshake and asserts stall back to the ISDU when the FIFO is full.

Parameters:
- DEPTH, 4: FIFO entries; must be a power of two, 2..16.
- TIMEOUT, 1023: cycles to wait for acknowledge before declaring an error. Used only with GPU_TIMEOUT_EN.

Ports:
- Clk, in, 1: system clock.
- Reset_ah, in, 1: asynchronous, active-high reset.
- issue, in, 1: one-cycle push request from the ISDU.
- IR, in, 16: instruction; IR[11:9] is the command code, IR[7:0] is the command data.
- R0, in, 16: operand 0 (X).
- R1, in, 16: operand 1 (Y).
- R2, in, 16: operand 2 (colour/length).
- command, out, 3: command code presented to the graphics unit.
- command_data, out, 8: data presented with command.
- op0, out, 16: latched R0 for the current command.
- op1, out, 16: latched R1 for the current command.
- op2, out, 16: latched R2 for the current command.
- command_ready, out, 2: transmit sequence number; increments once per new command.
- command_received, in, 2: receiver's copy of the last consumed sequence number.
- stall, out, 1: FIFO full, or error state (timeout build); the ISDU must hold off issue.
- empty, out, 1: FIFO empty and no command outstanding.
- count, out, $clog2(DEPTH)+1: FIFO occupancy, excluding the in-flight command.
- overflow, out, 1: sticky; an issue was dropped.
- timeout, out, 1: sticky; acknowledge timeout. Tied to 0 without GPU_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, FIFO pointers and count=0, command=0, command_data=0, op0/op1/op2=0, command_ready=2'b00, overflow=0, timeout=0. Outputs then read stall=0, empty=1. The graphics unit shares Reset_ah, so command_received also returns to 0 and the two ends resynchronise.
- FIFO entry is 59 bits: {IR[11:9], IR[7:0], R0, R1, R2}. Fields are sampled on the rising edge where issue=1.
- Push rule: issue=1 with count<DEPTH writes at the tail.
- Push when full, pop same edge: accepted; count is unchanged.
- Push when full, no pop: entry dropped; overflow<=1.
- Handshake: a command is outstanding while command_ready != command_received. The receiver acknowledges by making command_received equal command_ready. No synchroniser; same clock domain. command, command_data and op0–op2 stay constant while outstanding.
- IDLE:
  - If count>0, on the edge: load outputs from the head, pop, command_ready<=command_ready+1 (mod 4), go WAIT.
  - An entry pushed at edge N is therefore presented at edge N+1 when IDLE and empty. Latency is 1 cycle.
- WAIT:
  - If command_received==command_ready and count>0: load the next head, pop, increment command_ready, stay WAIT. This gives back-to-back issue, one command per ack cycle.
  - If the ack arrives and count==0: go IDLE. Outputs hold their last values.
  - Otherwise: hold.
- Wrap-around: command_ready wraps 3 to 0. Equality compare only; at most one command is outstanding.
- Pushes to an empty FIFO during WAIT queue normally; there is no bypass.
- empty = (count==0) && (state==IDLE).
- stall = (count==DEPTH), OR'd with state==ERROR when built with GPU_TIMEOUT_EN.
- overflow clears only on Reset_ah.

Optional Feature:
- Macro: GPU_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter clears on entry to WAIT and on each accepted ack, and increments every WAIT cycle.
  - Reaching TIMEOUT sets timeout<=1 and moves to state ERROR.
  - ERROR holds outputs and command_ready, forces stall=1, ignores further issue without setting overflow, and exits only on Reset_ah.
- Without the macro: no counter and no ERROR state; timeout is constant 0; WAIT holds indefinitely.

Test Plan:
- Reset, then issue once with IR=16'h0A55 (cmd 5, data 8'h55), R0=16'd10, R1=16'd20, R2=16'h00FF. Expected: next edge command=3'd5, command_data=8'h55, op0=10, op1=20, op2=16'h00FF, command_ready=2'b01. Hold command_received=0 for 5 cycles and outputs stay stable. Drive command_received=2'b01: next edge state=IDLE, empty=1.
- Issue 5 commands back-to-back with no ack, DEPTH=4. Expected: 1 in flight, then count reaches 4 and stall=1. A sixth issue is dropped and overflow=1.
- Ack immediately every cycle across 6 commands. Expected: command_ready steps 1,2,3,0,1,2; commands appear in FIFO order with no gaps beyond 1 cycle per ack.
- FIFO full with ack and issue on the same edge. Expected: push accepted, count stays 4, overflow stays 0.
- Assert Reset_ah mid-WAIT with count=2. Expected: immediately command_ready=0, count=0, op0=0, stall=0, empty=1. A fresh issue afterwards presents with command_ready=2'b01.
- With GPU_TIMEOUT_EN and TIMEOUT=8, issue once and never ack. Expected: after 8 WAIT cycles timeout=1 and stall=1; later issues are ignored and outputs are unchanged until reset.
